// File: rtl/gbe_sw_port_loader.sv
// gbe_sw_port_loader
// Takes the GbE UDP port from a 32-bit software register, waits until the
// value has been steady for a while, then offers it to the 10GbE core config
// interface with a valid/ack handshake. Adds an ack timeout with a sticky
// error flag and a count of successful loads for software readback.
//
// Ports
//   user_clk        block clock
//   user_rst_n      asynchronous active-low reset
//   sw_data_in      software register; only [PORT_WIDTH-1:0] is used
//   enable          allows a new qualification to start
//   cfg_port        port value offered to the core (held while cfg_valid)
//   cfg_valid       load request
//   cfg_ack         core accepts cfg_port (ignored outside a request)
//   committed_port  last port value acknowledged by the core
//   load_count      number of successful loads, wraps at 0xFFFF
//   timeout_err     sticky: a request was abandoned without ack
//   err_clr         clears timeout_err (a coincident new error wins)
module gbe_sw_port_loader #(
    parameter int unsigned PORT_WIDTH    = 16,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT   = 255
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic [31:0]           sw_data_in,
    input  logic                  enable,
    output logic [PORT_WIDTH-1:0] cfg_port,
    output logic                  cfg_valid,
    input  logic                  cfg_ack,
    output logic [PORT_WIDTH-1:0] committed_port,
    output logic [15:0]           load_count,
    output logic                  timeout_err,
    input  logic                  err_clr
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TO_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        REQUEST = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [PORT_WIDTH-1:0] s1;
    logic [PORT_WIDTH-1:0] cand, cand_nxt;
    logic [STAB_W-1:0]     stab_cnt, stab_nxt;
    logic [TO_W-1:0]       to_cnt, to_nxt;
    logic [PORT_WIDTH-1:0] port_nxt;
    logic                  valid_nxt;
    logic [PORT_WIDTH-1:0] commit_nxt;
    logic [15:0]           count_nxt;
    logic                  err_set;
    logic                  err_nxt;

    // Upper register bits carry nothing for this block.
    generate
        if (PORT_WIDTH < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^sw_data_in[31:PORT_WIDTH];
        end
    endgenerate

    // State, sample register and all registered outputs.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state          <= IDLE;
            s1             <= '0;
            cand           <= '0;
            stab_cnt       <= '0;
            to_cnt         <= '0;
            cfg_port       <= '0;
            cfg_valid      <= 1'b0;
            committed_port <= '0;
            load_count     <= '0;
            timeout_err    <= 1'b0;
        end else begin
            state          <= state_nxt;
            s1             <= sw_data_in[PORT_WIDTH-1:0];
            cand           <= cand_nxt;
            stab_cnt       <= stab_nxt;
            to_cnt         <= to_nxt;
            cfg_port       <= port_nxt;
            cfg_valid      <= valid_nxt;
            committed_port <= commit_nxt;
            load_count     <= count_nxt;
            timeout_err    <= err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        stab_nxt   = stab_cnt;
        to_nxt     = to_cnt;
        port_nxt   = cfg_port;
        valid_nxt  = cfg_valid;
        commit_nxt = committed_port;
        count_nxt  = load_count;
        err_set    = 1'b0;

        unique case (state)
            IDLE: begin
                if (enable && (s1 != committed_port)) begin
                    state_nxt = QUALIFY;
                    cand_nxt  = s1;
                    stab_nxt  = STAB_W'(1);
                end
            end

            // stab_cnt counts candidate matches since entry; the request is
            // raised on the edge that finds the count already at
            // STABLE_CYCLES, i.e. STABLE_CYCLES+1 edges after s1 captured it.
            QUALIFY: begin
                if (!enable || (s1 == committed_port)) begin
                    state_nxt = IDLE;
                end else if (s1 != cand) begin
                    cand_nxt = s1;
                    stab_nxt = STAB_W'(1);
                end else if (stab_cnt == STAB_W'(STABLE_CYCLES)) begin
                    state_nxt = REQUEST;
                    port_nxt  = cand;
                    valid_nxt = 1'b1;
                    to_nxt    = '0;
                end else begin
                    stab_nxt = stab_cnt + STAB_W'(1);
                end
            end

            // Ack is checked before the timeout so a coincident ack wins.
            REQUEST: begin
                if (cfg_ack) begin
                    commit_nxt = cfg_port;
                    count_nxt  = load_count + 16'd1;
                    valid_nxt  = 1'b0;
                    state_nxt  = IDLE;
                end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    valid_nxt = 1'b0;
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    to_nxt = to_cnt + TO_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Sticky error: a new timeout beats a coincident clear.
        if (err_set) begin
            err_nxt = 1'b1;
        end else if (err_clr) begin
            err_nxt = 1'b0;
        end else begin
            err_nxt = timeout_err;
        end
    end

endmodule
